// File: rtl/convert_fixed_to_float.sv
// convert_fixed_to_float
//   Converts a signed Q5.26 fixed-point value to an IEEE-754 single-precision
//   float. It takes the absolute value, then normalizes one bit per cycle until
//   the leading one reaches the MSB, and finally packs the result. The mantissa
//   is truncated, which rounds toward zero.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-high reset; aborts any conversion in flight
//   START  in   request a conversion; sampled only while idle
//   FIXED  in   [P-1:0] signed Q5.26 operand, captured with an accepted START
//   BUSY   out  high whenever the FSM is not idle
//   DONE   out  one-cycle pulse; FLOAT and ZERO are valid from this cycle on
//   FLOAT  out  [P-1:0] IEEE-754 result, held until the next DONE
//   ZERO   out  high with the result when the input was zero
module convert_fixed_to_float #(
    parameter int P    = 32,
    parameter int W    = 8,
    parameter int FRAC = 26
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [P-1:0] FIXED,
    output logic         BUSY,
    output logic         DONE,
    output logic [P-1:0] FLOAT,
    output logic         ZERO
);
    localparam int CW   = $clog2(P);
    localparam int MANT = P - W - 1;
    // Exponent when the leading one already sits at bit P-1 (no shifts).
    localparam logic [W-1:0] BIAS = W'(127 + (P - 1) - FRAC);

    typedef enum logic [1:0] {IDLE, ABS, NORM, PACK} state_t;

    state_t         state_q, state_d;
    logic [P-1:0]   in_q, in_d;
    logic [P-1:0]   mag_q, mag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sign_q, sign_d;
    logic [P-1:0]   float_q, float_d;
    logic           zero_q, zero_d;
    logic           done_q, done_d;
    logic [W-1:0]   exp_w;

    // Every left shift lowers the exponent by one.
    assign exp_w = BIAS - W'(cnt_q);

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        float_d = float_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    in_d    = FIXED;
                    state_d = ABS;
                end
            end
            ABS: begin
                // The most negative input negates to itself, which read as
                // unsigned is exactly the required magnitude 2^(P-1).
                sign_d  = in_q[P-1];
                mag_d   = in_q[P-1] ? ('0 - in_q) : in_q;
                cnt_d   = '0;
                state_d = NORM;
            end
            NORM: begin
                if (mag_q[P-1] || (mag_q == '0)) begin
                    state_d = PACK;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PACK: begin
                if (mag_q == '0) begin
                    float_d = '0;
                    zero_d  = 1'b1;
                end else begin
                    float_d = {sign_q, exp_w, mag_q[P-2 -: MANT]};
                    zero_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            in_q    <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            float_q <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            float_q <= float_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign BUSY  = (state_q != IDLE);
    assign DONE  = done_q;
    assign FLOAT = float_q;
    assign ZERO  = zero_q;

endmodule

// File: tb/tb_convert_fixed_to_float.sv
// Scoreboard bench for convert_fixed_to_float: a posedge model process pushes
// the expected result and completion cycle of every accepted START, and a
// negedge monitor pops and compares whenever DONE is seen.
module tb_convert_fixed_to_float;
    logic        CLK = 1'b0;
    logic        RST, START;
    logic [31:0] FIXED;
    logic        BUSY, DONE, ZERO;
    logic [31:0] FLOAT;

    convert_fixed_to_float dut (
        .CLK(CLK), .RST(RST), .START(START), .FIXED(FIXED),
        .BUSY(BUSY), .DONE(DONE), .FLOAT(FLOAT), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] f;
        logic        z;
        int          done_cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          free_at = 0;
    int          busy_lo = 0, busy_hi = 0;
    int          rst_cyc = -1;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] hold_f = '0;
    logic        hold_z = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endfunction

    // Reference: value = x / 2^26; float = sign * 2^e * 1.m with the mantissa
    // truncated to 23 bits. Latency is 3 cycles plus one per normalizing shift.
    function automatic exp_t ref_conv(logic [31:0] x, output int lat);
        exp_t   r;
        longint v, mag, m;
        int     lead;
        v   = longint'($signed(x));
        mag = (v < 0) ? -v : v;
        r.done_cyc = 0;
        if (mag == 0) begin
            r.f = 32'h0;
            r.z = 1'b1;
            lat = 3;
        end else begin
            lead = 0;
            while ((mag >> (lead + 1)) != 0) lead++;
            if (lead >= 23) m = mag >> (lead - 23);
            else            m = mag << (23 - lead);
            r.f[31]    = (v < 0);
            r.f[30:23] = 8'(127 + lead - 26);
            r.f[22:0]  = 23'(m);
            r.z = 1'b0;
            lat = 3 + (31 - lead);
        end
        return r;
    endfunction

    // Model: decides which STARTs the converter accepts and what they produce.
    always @(posedge CLK) begin
        exp_t e;
        int   lat;
        cyc++;
        if (RST) begin
            q.delete();
            busy_hi = 0;
            free_at = cyc + 1;
            rst_cyc = cyc;
        end else if (START && cyc >= free_at) begin
            e = ref_conv(FIXED, lat);
            e.done_cyc = cyc + lat;
            q.push_back(e);
            busy_lo = cyc;
            busy_hi = cyc + lat;
            free_at = cyc + lat + 1;
        end
    end

    // Monitor
    always @(negedge CLK) begin
        exp_t e;
        if (cyc > 0) begin
            if (rst_cyc == cyc) begin
                hold_f = '0;
                hold_z = 1'b0;
            end
            chk("busy", 32'(BUSY), 32'(cyc >= busy_lo && cyc < busy_hi));
            if (DONE) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done cyc=%0d got DONE=1 expected DONE=0", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    hold_f = e.f;
                    hold_z = e.z;
                end
            end else if (q.size() > 0 && cyc >= q[0].done_cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_done cyc=%0d got DONE=0 expected DONE=1", cyc);
                void'(q.pop_front());
            end
            chk("float", FLOAT, hold_f);
            chk("zero", 32'(ZERO), 32'(hold_z));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && cyc + 1 < free_at; i++) tick();
    endtask

    task automatic send(logic [31:0] v);
        wait_idle();
        START = 1'b1;
        FIXED = v;
        tick();
        START = 1'b0;
        FIXED = $urandom;
        wait_idle();
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom_range(3))
            0: v = $urandom;
            1: v = $urandom >> $urandom_range(31);
            2: v = 32'h0 - ($urandom >> $urandom_range(31));
            default: begin
                case ($urandom_range(4))
                    0: v = 32'h0;
                    1: v = 32'h80000000;
                    2: v = 32'h7FFFFFFF;
                    3: v = 32'hFFFFFFFF;
                    default: v = 32'h1 << $urandom_range(31);
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        FIXED = '0;
        repeat (3) tick();
        RST = 1'b0;

        send(32'h04000000);
        send(32'hFC000000);
        send(32'h80000000);
        send(32'h00000000);
        send(32'h00000001);
        send(32'h7FFFFFFF);

        // Abort a long conversion mid-normalization, then restart.
        START = 1'b1;
        FIXED = 32'h00000001;
        tick();
        START = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        send(32'h04000000);

        repeat (60) send(rnd_val());

        // START held high with FIXED changing every cycle.
        START = 1'b1;
        repeat (300) begin
            FIXED = rnd_val();
            tick();
        end
        START = 1'b0;

        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got %0d pending expected 0 pending", q.size());
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
